// File: rtl/bp_pkg.sv
// ============================================================================
// Module      : bp_pkg
// Description : Shared types, mode encodings and reset-value helpers for the
//               branch target predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_pkg;

    localparam int BP_MODE_STATIC  = 0;
    localparam int BP_MODE_BIMODAL = 1;

    // Entry fields are sized for the widest legal configuration; narrower
    // configurations keep the upper bits at zero.
    localparam int c_MAX_TAG_BITS = 30;
    localparam int c_MAX_CTR_BITS = 4;

    typedef logic [c_MAX_TAG_BITS-1:0] bp_tag_t;
    typedef logic [c_MAX_CTR_BITS-1:0] bp_ctr_t;

    typedef struct packed {
        logic        valid;
        bp_tag_t     tag;
        logic [31:0] target;
        bp_ctr_t     ctr;
    } btb_entry_t;

    function automatic int bp_index_bits(input int entries);
        return $clog2(entries);
    endfunction

    function automatic bp_ctr_t bp_ctr_wt(input int ctrBits);
        return bp_ctr_t'(1 << (ctrBits - 1));
    endfunction

    function automatic bp_ctr_t bp_ctr_wnt(input int ctrBits);
        return bp_ctr_t'((1 << (ctrBits - 1)) - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_sat_counter.sv
// ============================================================================
// Module      : bp_sat_counter
// Description : Next-state logic for one saturating prediction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_sat_counter #(
    parameter int CTR_BITS = 2,
    parameter int WIDTH    = 4
) (
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadValue,
    input  logic [WIDTH-1:0] i_ctr,
    output logic [WIDTH-1:0] o_ctr
);

    localparam logic [WIDTH-1:0] c_CTR_MAX = WIDTH'((1 << CTR_BITS) - 1);

    always_comb begin
        o_ctr = i_ctr;
        if (i_load) begin
            o_ctr = i_loadValue;
        end else if (i_inc && (i_ctr < c_CTR_MAX)) begin
            o_ctr = i_ctr + 1'b1;
        end else if (i_dec && (i_ctr != '0)) begin
            o_ctr = i_ctr - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_target_predictor.sv
// ============================================================================
// Module      : branch_target_predictor
// Description : Tagged bimodal branch predictor / BTB with mispredict stats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2,
    parameter int MODE     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] lookup_pc,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    output logic        btb_hit,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_pred_taken,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int      c_INDEX_BITS = bp_index_bits(ENTRIES);
    localparam int      c_TAG_LSB    = c_INDEX_BITS + 2;
    localparam int      c_TAG_TOP    = c_TAG_LSB + TAG_BITS;
    localparam bp_ctr_t c_CTR_WT     = bp_ctr_wt(CTR_BITS);
    localparam bp_ctr_t c_CTR_WNT    = bp_ctr_wnt(CTR_BITS);
    localparam bit      c_BIMODAL    = (MODE == BP_MODE_BIMODAL);

    btb_entry_t              r_table [ENTRIES];
    logic [31:0]             r_branchCount;
    logic [31:0]             r_mispredictCount;

    logic [c_INDEX_BITS-1:0] w_lookupIdx;
    logic [c_INDEX_BITS-1:0] w_updateIdx;
    bp_tag_t                 w_lookupTag;
    bp_tag_t                 w_updateTag;
    btb_entry_t              w_lookupEntry;
    btb_entry_t              w_updateEntry;
    btb_entry_t              w_newEntry;
    logic                    w_lookupHit;
    logic                    w_updateHit;
    logic                    w_tableWrite;
    bp_ctr_t                 w_nextCtr;
    logic                    w_unusedBits;

    // Byte-offset bits and PC bits above the tag never participate.
    assign w_unusedBits = ^{lookup_pc[1:0], update_pc[1:0],
                            lookup_pc >> c_TAG_TOP, update_pc >> c_TAG_TOP};

    // ---------------- lookup ----------------
    assign w_lookupIdx   = lookup_pc[c_TAG_LSB-1:2];
    assign w_lookupTag   = bp_tag_t'(lookup_pc[c_TAG_LSB +: TAG_BITS]);
    assign w_lookupEntry = r_table[w_lookupIdx];
    assign w_lookupHit   = w_lookupEntry.valid && (w_lookupEntry.tag == w_lookupTag);

    always_comb begin
        btb_hit        = 1'b0;
        predict_taken  = 1'b0;
        predict_target = '0;
        if (c_BIMODAL) begin
            btb_hit        = w_lookupHit;
            predict_taken  = w_lookupHit && w_lookupEntry.ctr[CTR_BITS-1];
            predict_target = predict_taken ? w_lookupEntry.target : '0;
        end
    end

    // ---------------- update ----------------
    assign w_updateIdx   = update_pc[c_TAG_LSB-1:2];
    assign w_updateTag   = bp_tag_t'(update_pc[c_TAG_LSB +: TAG_BITS]);
    assign w_updateEntry = r_table[w_updateIdx];
    assign w_updateHit   = w_updateEntry.valid && (w_updateEntry.tag == w_updateTag);

    bp_sat_counter #(
        .CTR_BITS (CTR_BITS),
        .WIDTH    (c_MAX_CTR_BITS)
    ) u_satCounter (
        .i_inc       (w_updateHit && update_taken),
        .i_dec       (w_updateHit && !update_taken),
        .i_load      (!w_updateHit),
        .i_loadValue (c_CTR_WT),
        .i_ctr       (w_updateEntry.ctr),
        .o_ctr       (w_nextCtr)
    );

    always_comb begin
        w_newEntry     = w_updateEntry;
        w_newEntry.ctr = w_nextCtr;
        if (update_taken) begin
            w_newEntry.valid  = 1'b1;
            w_newEntry.tag    = w_updateTag;
            w_newEntry.target = update_target;
        end
    end

    // A not-taken miss leaves the table alone rather than allocating.
    assign w_tableWrite = c_BIMODAL && update_valid && (w_updateHit || update_taken);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i].valid <= 1'b0;
                r_table[i].ctr   <= c_CTR_WNT;
            end
        end else if (w_tableWrite) begin
            r_table[w_updateIdx] <= w_newEntry;
        end
    end

    // ---------------- statistics ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_branchCount     <= '0;
            r_mispredictCount <= '0;
        end else if (update_valid) begin
            r_branchCount <= r_branchCount + 32'd1;
            if (update_pred_taken != update_taken) begin
                r_mispredictCount <= r_mispredictCount + 32'd1;
            end
        end
    end

    assign branch_count     = r_branchCount;
    assign mispredict_count = r_mispredictCount;

endmodule

`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
// ============================================================================
// Module      : tb_branch_target_predictor
// Description : Scoreboard bench for bimodal and static predictor instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_target_predictor;

    localparam int ENTRIES = 64;
    localparam int NTAG    = 8;
    localparam int NCTR    = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = '0;
    logic        update_pred_taken = 1'b0;

    logic        bHit, bTaken, sHit, sTaken;
    logic [31:0] bTarget, bBc, bMc, sTarget, sBc, sMc;

    always #5 clock = ~clock;

    branch_target_predictor #(.ENTRIES(ENTRIES), .TAG_BITS(NTAG), .CTR_BITS(NCTR), .MODE(1)) dutB (
        .clock(clock), .reset(reset), .lookup_pc(lookup_pc),
        .predict_taken(bTaken), .predict_target(bTarget), .btb_hit(bHit),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_pred_taken(update_pred_taken),
        .branch_count(bBc), .mispredict_count(bMc)
    );

    branch_target_predictor #(.ENTRIES(ENTRIES), .TAG_BITS(NTAG), .CTR_BITS(NCTR), .MODE(0)) dutS (
        .clock(clock), .reset(reset), .lookup_pc(lookup_pc),
        .predict_taken(sTaken), .predict_target(sTarget), .btb_hit(sHit),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_pred_taken(update_pred_taken),
        .branch_count(sBc), .mispredict_count(sMc)
    );

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic [31:0] bc;
        logic [31:0] mc;
        logic        sHit;
        logic        sTaken;
        logic [31:0] sTarget;
        logic [31:0] sBc;
        logic [31:0] sMc;
    } rec_t;

    rec_t expQ[$];
    rec_t obsQ[$];
    int   nTests = 0;
    int   nFail  = 0;

    // Reference model of the bimodal table and stats counters
    bit          mValid [ENTRIES];
    logic [7:0]  mTag   [ENTRIES];
    logic [31:0] mTarget[ENTRIES];
    int          mCtr   [ENTRIES];
    logic [31:0] mBranch = '0;
    logic [31:0] mMisp   = '0;

    task automatic model_edge(input bit rst, input bit uv, input logic [31:0] upc,
                              input bit ut, input logic [31:0] utgt, input bit upred);
        int  i;
        bit  hit;
        if (rst) begin
            for (int k = 0; k < ENTRIES; k++) begin
                mValid[k] = 1'b0;
                mCtr[k]   = 1;
            end
            mBranch = '0;
            mMisp   = '0;
        end else if (uv) begin
            mBranch = mBranch + 1;
            if (upred != ut) mMisp = mMisp + 1;
            i   = int'(upc[7:2]);
            hit = mValid[i] && (mTag[i] == upc[15:8]);
            if (hit) begin
                if (ut) begin
                    mCtr[i]    = (mCtr[i] < 3) ? mCtr[i] + 1 : 3;
                    mTarget[i] = utgt;
                end else begin
                    mCtr[i] = (mCtr[i] > 0) ? mCtr[i] - 1 : 0;
                end
            end else if (ut) begin
                mValid[i]  = 1'b1;
                mTag[i]    = upc[15:8];
                mTarget[i] = utgt;
                mCtr[i]    = 2;
            end
        end
    endtask

    // One cycle: drive at negedge, record expected and observed mid-cycle,
    // then advance the model at the rising edge.
    task automatic tick(input bit chk, input bit rst, input logic [31:0] lpc, input bit uv,
                        input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                        input bit upred);
        rec_t e;
        rec_t o;
        int   i;
        @(negedge clock);
        reset = rst; lookup_pc = lpc; update_valid = uv; update_pc = upc;
        update_taken = ut; update_target = utgt; update_pred_taken = upred;
        if (chk) begin
            i        = int'(lpc[7:2]);
            e        = '0;
            e.hit    = mValid[i] && (mTag[i] == lpc[15:8]);
            e.taken  = e.hit && (mCtr[i] >= 2);
            e.target = e.taken ? mTarget[i] : 32'h0;
            e.bc     = mBranch;
            e.mc     = mMisp;
            e.sBc    = mBranch;
            e.sMc    = mMisp;
            expQ.push_back(e);
            #1;
            o = '{bHit, bTaken, bTarget, bBc, bMc, sHit, sTaken, sTarget, sBc, sMc};
            obsQ.push_back(o);
        end
        @(posedge clock);
        model_edge(rst, uv, upc, ut, utgt, upred);
    endtask

    task automatic test_reset();
        rec_t e, o;
        tick(0, 1, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        tick(1, 0, 32'h0040_0010, 0, 32'h0, 0, 32'h0, 0);
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); nTests++;
            if (o !== e) begin
                nFail++;
                $display("FAIL reset: got hit=%b tk=%b tgt=%h bc=%0d mc=%0d s=%b%b%h/%0d/%0d, expected hit=%b tk=%b tgt=%h bc=%0d mc=%0d",
                         o.hit, o.taken, o.target, o.bc, o.mc, o.sHit, o.sTaken, o.sTarget, o.sBc, o.sMc,
                         e.hit, e.taken, e.target, e.bc, e.mc);
            end
        end
    endtask

    task automatic test_allocate();
        rec_t e, o;
        tick(1, 0, 32'h0040_0010, 1, 32'h0040_0010, 1, 32'h0040_0040, 0);
        tick(1, 0, 32'h0040_0010, 0, 32'h0, 0, 32'h0, 0);
        #1; nTests++;
        if (bHit !== 1'b1 || bTaken !== 1'b1 || bTarget !== 32'h0040_0040 || bMc !== 32'd1) begin
            nFail++;
            $display("FAIL allocate_direct: got hit=%b tk=%b tgt=%h mc=%0d, expected 1 1 00400040 1",
                     bHit, bTaken, bTarget, bMc);
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); nTests++;
            if (o !== e) begin
                nFail++;
                $display("FAIL allocate: got hit=%b tk=%b tgt=%h bc=%0d mc=%0d s=%b%b%h/%0d/%0d, expected hit=%b tk=%b tgt=%h bc=%0d mc=%0d",
                         o.hit, o.taken, o.target, o.bc, o.mc, o.sHit, o.sTaken, o.sTarget, o.sBc, o.sMc,
                         e.hit, e.taken, e.target, e.bc, e.mc);
            end
        end
    endtask

    task automatic test_saturate();
        rec_t e, o;
        for (int k = 0; k < 3; k++)
            tick(1, 0, 32'h0040_0010, 1, 32'h0040_0010, 0, 32'h0, 1);
        tick(1, 0, 32'h0040_0010, 1, 32'h0040_0010, 1, 32'h0040_0040, 0);
        tick(1, 0, 32'h0040_0010, 1, 32'h0040_0010, 1, 32'h0040_0044, 0);
        tick(1, 0, 32'h0040_0010, 0, 32'h0, 0, 32'h0, 0);
        #1; nTests++;
        if (bTaken !== 1'b1 || bTarget !== 32'h0040_0044) begin
            nFail++;
            $display("FAIL saturate_direct: got tk=%b tgt=%h, expected 1 00400044", bTaken, bTarget);
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); nTests++;
            if (o !== e) begin
                nFail++;
                $display("FAIL saturate: got hit=%b tk=%b tgt=%h bc=%0d mc=%0d s=%b%b%h/%0d/%0d, expected hit=%b tk=%b tgt=%h bc=%0d mc=%0d",
                         o.hit, o.taken, o.target, o.bc, o.mc, o.sHit, o.sTaken, o.sTarget, o.sBc, o.sMc,
                         e.hit, e.taken, e.target, e.bc, e.mc);
            end
        end
    endtask

    task automatic test_alias();
        rec_t e, o;
        tick(1, 0, 32'h0040_0110, 0, 32'h0, 0, 32'h0, 0);
        tick(1, 0, 32'h0040_0110, 1, 32'h0040_0110, 1, 32'h0040_0200, 0);
        tick(1, 0, 32'h0040_0010, 0, 32'h0, 0, 32'h0, 0);
        tick(1, 0, 32'h0040_0110, 0, 32'h0, 0, 32'h0, 0);
        #1; nTests++;
        if (bHit !== 1'b1 || bTarget !== 32'h0040_0200) begin
            nFail++;
            $display("FAIL alias_direct: got hit=%b tgt=%h, expected 1 00400200", bHit, bTarget);
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); nTests++;
            if (o !== e) begin
                nFail++;
                $display("FAIL alias: got hit=%b tk=%b tgt=%h bc=%0d mc=%0d s=%b%b%h/%0d/%0d, expected hit=%b tk=%b tgt=%h bc=%0d mc=%0d",
                         o.hit, o.taken, o.target, o.bc, o.mc, o.sHit, o.sTaken, o.sTarget, o.sBc, o.sMc,
                         e.hit, e.taken, e.target, e.bc, e.mc);
            end
        end
    endtask

    task automatic test_read_during_write();
        rec_t e, o;
        tick(1, 0, 32'h0040_0020, 1, 32'h0040_0020, 1, 32'h0040_0080, 1);
        tick(1, 0, 32'h0040_0020, 0, 32'h0, 0, 32'h0, 0);
        tick(1, 1, 32'h0040_0030, 1, 32'h0040_0030, 1, 32'h0040_00C0, 0);
        tick(1, 0, 32'h0040_0030, 0, 32'h0, 0, 32'h0, 0);
        #1; nTests++;
        if (bHit !== 1'b0 || bBc !== 32'd0 || bMc !== 32'd0) begin
            nFail++;
            $display("FAIL reset_with_update: got hit=%b bc=%0d mc=%0d, expected 0 0 0", bHit, bBc, bMc);
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); nTests++;
            if (o !== e) begin
                nFail++;
                $display("FAIL read_during_write: got hit=%b tk=%b tgt=%h bc=%0d mc=%0d s=%b%b%h/%0d/%0d, expected hit=%b tk=%b tgt=%h bc=%0d mc=%0d",
                         o.hit, o.taken, o.target, o.bc, o.mc, o.sHit, o.sTaken, o.sTarget, o.sBc, o.sMc,
                         e.hit, e.taken, e.target, e.bc, e.mc);
            end
        end
    endtask

    task automatic test_static_mode();
        rec_t e, o;
        tick(0, 1, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        for (int k = 0; k < 10; k++)
            tick(1, 0, 32'h0040_0050, 1, 32'h0040_0050, 1, 32'h0040_1000 + 32'(k * 4), 0);
        tick(1, 0, 32'h0040_0050, 0, 32'h0, 0, 32'h0, 0);
        #1; nTests++;
        if (sTaken !== 1'b0 || sBc !== 32'd10 || sMc !== 32'd10) begin
            nFail++;
            $display("FAIL static_counts: got tk=%b bc=%0d mc=%0d, expected 0 10 10", sTaken, sBc, sMc);
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); nTests++;
            if (o !== e) begin
                nFail++;
                $display("FAIL static_mode: got hit=%b tk=%b tgt=%h bc=%0d mc=%0d s=%b%b%h/%0d/%0d, expected hit=%b tk=%b tgt=%h bc=%0d mc=%0d",
                         o.hit, o.taken, o.target, o.bc, o.mc, o.sHit, o.sTaken, o.sTarget, o.sBc, o.sMc,
                         e.hit, e.taken, e.target, e.bc, e.mc);
            end
        end
    endtask

    task automatic test_back_to_back();
        rec_t        e, o;
        logic [31:0] lpc, upc;
        for (int k = 0; k < 48; k++) begin
            lpc = 32'h0040_0000 | (32'($urandom_range(0, 3)) << 2) | (32'($urandom_range(0, 1)) << 8);
            upc = 32'h0040_0000 | (32'($urandom_range(0, 3)) << 2) | (32'($urandom_range(0, 1)) << 8);
            tick(1, 0, lpc, 1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)),
                 32'h0050_0000 + 32'(k * 16), 1'($urandom_range(0, 1)));
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); nTests++;
            if (o !== e) begin
                nFail++;
                $display("FAIL back_to_back: got hit=%b tk=%b tgt=%h bc=%0d mc=%0d s=%b%b%h/%0d/%0d, expected hit=%b tk=%b tgt=%h bc=%0d mc=%0d",
                         o.hit, o.taken, o.target, o.bc, o.mc, o.sHit, o.sTaken, o.sTarget, o.sBc, o.sMc,
                         e.hit, e.taken, e.target, e.bc, e.mc);
            end
        end
    endtask

    task automatic test_counter_wrap();
        @(negedge clock);
        update_valid = 1'b0;
        force dutS.r_branchCount = 32'hFFFF_FFFF;
        @(negedge clock);
        release dutS.r_branchCount;
        #1; nTests++;
        if (sBc !== 32'hFFFF_FFFF) begin
            nFail++;
            $display("FAIL wrap_preload: got bc=%h, expected ffffffff", sBc);
        end
        update_valid = 1'b1; update_taken = 1'b0; update_pred_taken = 1'b0;
        @(posedge clock);
        #1;
        update_valid = 1'b0;
        nTests++;
        if (sBc !== 32'h0) begin
            nFail++;
            $display("FAIL wrap: got bc=%h, expected 00000000", sBc);
        end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_saturate();
        test_alias();
        test_read_during_write();
        test_static_mode();
        test_back_to_back();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

`default_nettype wire
